// File: rtl/axis_flit_credit_serializer_if.sv
// ---------------------------------------------------------------------------
// axis_flit_credit_serializer_if
//   AXI-Stream beat channel feeding the flit serializer.
//   Signals:
//     tvalid - beat valid (master -> slave)
//     tready - beat accepted when high together with tvalid (slave -> master)
//     tdata  - beat payload, TDATA_WIDTH bits
//     tlast  - last beat of a packet
//     tid    - stream id, TID_WIDTH bits
//     tdest  - destination, TDEST_WIDTH bits
//   Modports: master (upstream source), slave (serializer input).
// ---------------------------------------------------------------------------
interface axis_flit_credit_serializer_if #(
    parameter int TDATA_WIDTH = 128,
    parameter int TID_WIDTH   = 2,
    parameter int TDEST_WIDTH = 2
);
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tlast;
    logic [TID_WIDTH-1:0]   tid;
    logic [TDEST_WIDTH-1:0] tdest;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        output tid,
        output tdest,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        input  tid,
        input  tdest,
        output tready
    );
endinterface

// File: rtl/axis_flit_credit_serializer.sv
// ---------------------------------------------------------------------------
// axis_flit_credit_serializer
//   Router local-port injection block. Each accepted AXIS beat is cut into
//   SERIALIZATION_FACTOR flits which leave least-significant slice first,
//   one per cycle, each tagged with {tid, tdest}. A flit is sent only while
//   a downstream credit is held; credits come back one per credit_in pulse.
//
//   Ports:
//     clk_noc         - clock
//     rst_noc         - synchronous active-high reset
//     axis_in         - AXIS beat input (slave modport)
//     data_out        - flit payload (registered)
//     dest_out        - {tid, tdest} of the beat the flit belongs to
//     is_tail_out     - flit is the last flit of a packet
//     send_out        - flit valid, one cycle per flit
//     credit_in       - one downstream buffer slot freed
//     credit_count    - credits currently held
//     credit_overflow - sticky: credit returned while already at full depth
// ---------------------------------------------------------------------------
module axis_flit_credit_serializer #(
    parameter int TDATA_WIDTH          = 128,
    parameter int SERIALIZATION_FACTOR = 4,
    parameter int TID_WIDTH            = 2,
    parameter int TDEST_WIDTH          = 2,
    parameter int DEST_WIDTH           = TID_WIDTH + TDEST_WIDTH,
    parameter int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
    parameter int CREDIT_DEPTH         = 4,
    parameter int CNT_WIDTH            = $clog2(CREDIT_DEPTH + 1)
) (
    input  logic                          clk_noc,
    input  logic                          rst_noc,
    axis_flit_credit_serializer_if.slave  axis_in,
    output logic [FLIT_WIDTH-1:0]         data_out,
    output logic [DEST_WIDTH-1:0]         dest_out,
    output logic                          is_tail_out,
    output logic                          send_out,
    input  logic                          credit_in,
    output logic [CNT_WIDTH-1:0]          credit_count,
    output logic                          credit_overflow
);
    localparam int IDX_W = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX     = IDX_W'(SERIALIZATION_FACTOR - 1);
    localparam logic [CNT_WIDTH-1:0] FULL_CREDITS = CNT_WIDTH'(CREDIT_DEPTH);

    // Holding register for one accepted beat
    logic                   holding_reg;
    logic [TDATA_WIDTH-1:0] hold_data_reg;
    logic                   hold_last_reg;
    logic [DEST_WIDTH-1:0]  hold_dest_reg;
    logic [IDX_W-1:0]       idx_reg;

    logic [CNT_WIDTH-1:0]   credit_reg;
    logic                   overflow_reg;

    logic [FLIT_WIDTH-1:0]  data_reg;
    logic [DEST_WIDTH-1:0]  dest_reg;
    logic                   tail_reg;
    logic                   send_reg;

    logic                   fire;
    logic                   last_slice;
    logic                   accept;
    logic                   tready_int;

    // Slice view of the held beat, slice 0 = least-significant bits
    logic [FLIT_WIDTH-1:0]  slice_arr [SERIALIZATION_FACTOR];

    genvar gi;
    generate
        for (gi = 0; gi < SERIALIZATION_FACTOR; gi++) begin : g_slice
            assign slice_arr[gi] = hold_data_reg[gi*FLIT_WIDTH +: FLIT_WIDTH];
        end
    endgenerate

    assign fire       = holding_reg && (credit_reg != '0);
    assign last_slice = (idx_reg == LAST_IDX);
    // Ready while empty, or in the cycle the final slice leaves, so a new
    // beat can be loaded with no bubble between beats.
    assign tready_int = !holding_reg || (fire && last_slice);
    assign accept     = axis_in.tvalid && tready_int;

    assign axis_in.tready  = tready_int;
    assign data_out        = data_reg;
    assign dest_out        = dest_reg;
    assign is_tail_out     = tail_reg;
    assign send_out        = send_reg;
    assign credit_count    = credit_reg;
    assign credit_overflow = overflow_reg;

    always_ff @(posedge clk_noc) begin
        if (rst_noc) begin
            holding_reg   <= 1'b0;
            hold_data_reg <= '0;
            hold_last_reg <= 1'b0;
            hold_dest_reg <= '0;
            idx_reg       <= '0;
            credit_reg    <= FULL_CREDITS;
            overflow_reg  <= 1'b0;
            data_reg      <= '0;
            dest_reg      <= '0;
            tail_reg      <= 1'b0;
            send_reg      <= 1'b0;
        end else begin
            // Flit output stage
            if (fire) begin
                send_reg <= 1'b1;
                data_reg <= slice_arr[idx_reg];
                dest_reg <= hold_dest_reg;
                tail_reg <= hold_last_reg && last_slice;
                idx_reg  <= last_slice ? '0 : idx_reg + 1'b1;
            end else begin
                send_reg <= 1'b0;
                tail_reg <= 1'b0;
            end

            // Beat capture; idx is already 0 whenever a beat can be accepted
            if (accept) begin
                holding_reg   <= 1'b1;
                hold_data_reg <= axis_in.tdata;
                hold_last_reg <= axis_in.tlast;
                hold_dest_reg <= {axis_in.tid, axis_in.tdest};
            end else if (fire && last_slice) begin
                holding_reg <= 1'b0;
            end

            // Credit accounting; fire together with credit_in nets to zero
            unique case ({fire, credit_in})
                2'b10: credit_reg <= credit_reg - 1'b1;
                2'b01: begin
                    if (credit_reg == FULL_CREDITS) begin
                        overflow_reg <= 1'b1;
                    end else begin
                        credit_reg <= credit_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
